// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - clock digit inputs and multiplexed 7-segment outputs
interface seg_scan_if;
    logic       hourten;
    logic [3:0] hour;
    logic [2:0] minten;
    logic [3:0] min;
    logic       blink_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output hourten, hour, minten, min, blink_en,
        input  an, seg, dp
    );

    modport slave (
        input  hourten, hour, minten, min, blink_en,
        output an, seg, dp
    );
endinterface

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - 4-digit 7-segment scan driver with tear-free snapshot and blink; optional colon via DP_COLON_EN
module seg_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    seg_scan_if.slave   bus
);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    // Active-low cathode pattern {g,f,e,d,c,b,a} for a BCD digit
    function automatic logic [6:0] seg_code(input logic [3:0] v);
        logic [6:0] c;
        case (v)
            4'd0:    c = 7'h40;
            4'd1:    c = 7'h79;
            4'd2:    c = 7'h24;
            4'd3:    c = 7'h30;
            4'd4:    c = 7'h19;
            4'd5:    c = 7'h12;
            4'd6:    c = 7'h02;
            4'd7:    c = 7'h78;
            4'd8:    c = 7'h00;
            4'd9:    c = 7'h10;
            default: c = 7'h3F;
        endcase
        return c;
    endfunction

    logic [RW-1:0] ref_cnt_q, ref_cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic          snap_hourten_q, snap_hourten_d;
    logic [3:0]    snap_hour_q, snap_hour_d;
    logic [2:0]    snap_minten_q, snap_minten_d;
    logic [3:0]    snap_min_q, snap_min_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic          ref_tick;
    logic          blink_wrap;
    logic          capture;
    logic          blank;
    logic          lead_blank;
    logic [3:0]    digit_val;
    logic          digit_bad;

    // Counters, scan index and frame snapshot next-state
    always_comb begin
        ref_tick       = (ref_cnt_q == REF_LAST);
        blink_wrap     = (blink_cnt_q == BLINK_LAST);
        capture        = ref_tick && (idx_q == 2'd3);

        ref_cnt_d      = ref_tick ? '0 : ref_cnt_q + 1'b1;
        idx_d          = ref_tick ? idx_q + 2'd1 : idx_q;
        blink_cnt_d    = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d  = blink_phase_q ^ blink_wrap;

        snap_hourten_d = snap_hourten_q;
        snap_hour_d    = snap_hour_q;
        snap_minten_d  = snap_minten_q;
        snap_min_d     = snap_min_q;
        if (capture) begin
            snap_hourten_d = bus.hourten;
            snap_hour_d    = bus.hour;
            snap_minten_d  = bus.minten;
            snap_min_d     = bus.min;
        end
    end

    // Digit selection, decode and blanking for the next registered output
    always_comb begin
        digit_val = 4'd0;
        digit_bad = 1'b0;
        case (idx_q)
            2'd0: begin
                digit_val = snap_min_q;
                digit_bad = (snap_min_q > 4'd9);
            end
            2'd1: begin
                digit_val = {1'b0, snap_minten_q};
                digit_bad = (snap_minten_q > 3'd5);
            end
            2'd2: begin
                digit_val = snap_hour_q;
                digit_bad = (snap_hour_q > 4'd9);
            end
            default: begin
                digit_val = {3'b000, snap_hourten_q};
                digit_bad = 1'b0;
            end
        endcase

        blank      = bus.blink_en && blink_phase_q;
        lead_blank = (idx_q == 2'd3) && !snap_hourten_q;

        if (blank || lead_blank) begin
            an_d  = 4'b1111;
            seg_d = 7'h7F;
        end else begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = digit_bad ? 7'h3F : seg_code(digit_val);
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt_q      <= '0;
            idx_q          <= 2'd0;
            blink_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            snap_hourten_q <= 1'b0;
            snap_hour_q    <= 4'd0;
            snap_minten_q  <= 3'd0;
            snap_min_q     <= 4'd0;
            an_q           <= 4'b1111;
            seg_q          <= 7'h7F;
        end else begin
            ref_cnt_q      <= ref_cnt_d;
            idx_q          <= idx_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_phase_q  <= blink_phase_d;
            snap_hourten_q <= snap_hourten_d;
            snap_hour_q    <= snap_hour_d;
            snap_minten_q  <= snap_minten_d;
            snap_min_q     <= snap_min_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;

`ifdef DP_COLON_EN
    logic dp_q, dp_d;

    // Colon lit in the hour-ones slot during the first blink half-period
    always_comb begin
        dp_d = 1'b1;
        if (!blank && (idx_q == 2'd2) && !blink_phase_q) begin
            dp_d = 1'b0;
        end
    end

    // Colon output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_q <= 1'b1;
        end else begin
            dp_q <= dp_d;
        end
    end

    assign bus.dp = dp_q;
`else
    assign bus.dp = 1'b1;
`endif
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - randomized self-checking bench for seg_scan_driver
module tb_seg_scan_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    seg_scan_if bus();

    seg_scan_driver #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    int passes = 0;
    int checks = 0;
    int k      = 0;

    logic       m_hourten;
    logic [3:0] m_hour;
    logic [2:0] m_minten;
    logic [3:0] m_min;

    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;

    task automatic check_out(input string tag);
        checks++;
        assert (bus.an === exp_an) passes++;
        else $error("FAIL %s_an k=%0d observed=%b expected=%b", tag, k, bus.an, exp_an);
        checks++;
        assert (bus.seg === exp_seg) passes++;
        else $error("FAIL %s_seg k=%0d observed=%h expected=%h", tag, k, bus.seg, exp_seg);
        checks++;
        assert (bus.dp === exp_dp) passes++;
        else $error("FAIL %s_dp k=%0d observed=%b expected=%b", tag, k, bus.dp, exp_dp);
    endtask

    // k counts rising edges since reset release; outputs after edge k reflect
    // the scan position and blink half-period reached after k-1 edges.
    task automatic cycle(input string tag);
        int  d;
        int  ph;
        int  v;
        bit  bad;
        bit  blank;
        @(posedge clk);
        k++;
        d  = ((k - 1) / 4) % 4;
        ph = ((k - 1) / 8) % 2;
        case (d)
            0: begin v = int'(m_min);     bad = (v > 9); end
            1: begin v = int'(m_minten);  bad = (v > 5); end
            2: begin v = int'(m_hour);    bad = (v > 9); end
            default: begin v = int'(m_hourten); bad = 1'b0; end
        endcase
        blank = (bus.blink_en === 1'b1) && (ph == 1);
        if (blank || (d == 3 && v == 0)) begin
            exp_an  = 4'b1111;
            exp_seg = 7'h7F;
        end else begin
            exp_an  = 4'b1111;
            exp_an[d] = 1'b0;
            exp_seg = bad ? 7'h3F : seg_tab[v];
        end
`ifdef DP_COLON_EN
        exp_dp = (!blank && d == 2 && ph == 0) ? 1'b0 : 1'b1;
`else
        exp_dp = 1'b1;
`endif
        if (k % 16 == 0) begin
            m_hourten = bus.hourten;
            m_hour    = bus.hour;
            m_minten  = bus.minten;
            m_min     = bus.min;
        end
        @(negedge clk);
        check_out(tag);
    endtask

    task automatic model_reset();
        k         = 0;
        m_hourten = 1'b0;
        m_hour    = 4'd0;
        m_minten  = 3'd0;
        m_min     = 4'd0;
    endtask

    initial begin
        bus.hourten  = 1'b1;
        bus.hour     = 4'd2;
        bus.minten   = 3'd5;
        bus.min      = 4'd9;
        bus.blink_en = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        exp_an = 4'b1111; exp_seg = 7'h7F; exp_dp = 1'b1;
        check_out("reset");
        rst = 1'b0;

        // First frame shows zero snapshot, then 12:59 cycles
        repeat (48) cycle("fixed");

        // Change min to 3 while idx=1; visible only after next capture
        while ((k / 4) % 4 != 1) cycle("pre_min");
        bus.min = 4'd3;
        repeat (40) cycle("min_chg");

        // Invalid BCD hour and minten, leading-zero blanking
        bus.hour = 4'd12;
        bus.minten = 3'd7;
        bus.hourten = 1'b0;
        repeat (40) cycle("invalid");

        // Blink enabled continuously
        bus.hourten = 1'b1;
        bus.hour = 4'd0;
        bus.minten = 3'd0;
        bus.blink_en = 1'b1;
        repeat (64) cycle("blink");
        bus.blink_en = 1'b0;
        repeat (32) cycle("noblink");

        // Random inputs and blink_en
        repeat (200) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.hourten = 1'($urandom);
                bus.hour    = 4'($urandom);
                bus.minten  = 3'($urandom);
                bus.min     = 4'($urandom);
            end
            if ($urandom_range(0, 9) == 0) bus.blink_en = ~bus.blink_en;
            cycle("rand");
        end

        // Asynchronous reset mid-scan at idx=2
        bus.blink_en = 1'b0;
        while (((k / 4) % 4 != 2) || (k % 4 != 1)) cycle("pre_rst");
        #2 rst = 1'b1;
        #1;
        exp_an = 4'b1111; exp_seg = 7'h7F; exp_dp = 1'b1;
        check_out("async_rst");
        @(posedge clk);
        @(negedge clk);
        check_out("rst_hold");
        rst = 1'b0;
        model_reset();
        repeat (40) cycle("post_rst");

        repeat (100) begin
            bus.hourten  = 1'($urandom);
            bus.hour     = 4'($urandom);
            bus.minten   = 3'($urandom);
            bus.min      = 4'($urandom);
            bus.blink_en = 1'($urandom_range(0, 1));
            cycle("rand2");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
